// File: rtl/pixel_scaler.sv
// rtl/pixel_scaler.sv - ROM-to-RAM frame rescaler: replicate-up or decimate-down by 1, 2 or 4.
// Optional block averaging in decimate mode: define PIXEL_SCALER_AVG_EN.
module pixel_scaler #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [1:0]        factor_sel,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_we,
  input  logic              dst_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(SRC_W) + 1;
  localparam int RW = $clog2(SRC_H) + 1;
  localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
  localparam logic [CW-1:0]     SRC_W_C = CW'(SRC_W);
  localparam logic [RW-1:0]     SRC_H_C = RW'(SRC_H);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [1:0]         sh_q, sh_d;
  logic [1:0]         fm1_q, fm1_d;
  logic [RW-1:0]      r_q, r_d;
  logic [CW-1:0]      c_q, c_d;
  logic [1:0]         di_q, di_d;
  logic [1:0]         dj_q, dj_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [ADDR_W-1:0]  src_addr_q, src_addr_d;
  logic [ADDR_W-1:0]  dst_addr_q, dst_addr_d;
  logic [ADDR_W-1:0]  src_calc, dst_calc, row_base, col_base;
  logic [CW-1:0]      last_c;
  logic [RW-1:0]      last_r;
`ifdef PIXEL_SCALER_AVG_EN
  logic [1:0]         bi_q, bi_d;
  logic [1:0]         bj_q, bj_d;
  logic [PIX_W+3:0]   sum_q, sum_d, sum_next;
`endif

  // r/c index source pixels in replicate mode and output pixels in decimate mode.
  always_comb begin
    row_base = ADDR_W'(r_q) << sh_q;
    col_base = ADDR_W'(c_q) << sh_q;
    if (mode_q) begin
`ifdef PIXEL_SCALER_AVG_EN
      src_calc = (row_base + ADDR_W'(bi_q)) * SRC_W_A + col_base + ADDR_W'(bj_q);
`else
      src_calc = row_base * SRC_W_A + col_base;
`endif
      dst_calc = ADDR_W'(r_q) * (SRC_W_A >> sh_q) + ADDR_W'(c_q);
      last_c   = (SRC_W_C >> sh_q) - CW'(1);
      last_r   = (SRC_H_C >> sh_q) - RW'(1);
    end else begin
      src_calc = ADDR_W'(r_q) * SRC_W_A + ADDR_W'(c_q);
      dst_calc = (row_base + ADDR_W'(di_q)) * (SRC_W_A << sh_q) + col_base + ADDR_W'(dj_q);
      last_c   = SRC_W_C - CW'(1);
      last_r   = SRC_H_C - RW'(1);
    end
  end

  assign src_addr = (state_q == S_FETCH) ? src_calc : src_addr_q;
  assign dst_addr = (state_q == S_WRITE) ? dst_calc : dst_addr_q;
  assign dst_data = pix_q;
  assign dst_we   = (state_q == S_WRITE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sh_d       = sh_q;
    fm1_d      = fm1_q;
    r_d        = r_q;
    c_d        = c_q;
    di_d       = di_q;
    dj_d       = dj_q;
    pix_d      = pix_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
`ifdef PIXEL_SCALER_AVG_EN
    bi_d       = bi_q;
    bj_d       = bj_q;
    sum_d      = sum_q;
    sum_next   = sum_q + (PIX_W+4)'(src_data);
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          case (factor_sel)
            2'b01:   begin sh_d = 2'd1; fm1_d = 2'd1; end
            2'b10:   begin sh_d = 2'd2; fm1_d = 2'd3; end
            default: begin sh_d = 2'd0; fm1_d = 2'd0; end
          endcase
          r_d     = '0;
          c_d     = '0;
          di_d    = '0;
          dj_d    = '0;
`ifdef PIXEL_SCALER_AVG_EN
          bi_d    = '0;
          bj_d    = '0;
          sum_d   = '0;
`endif
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        src_addr_d = src_calc;
        state_d    = S_LATCH;
      end
      S_LATCH: begin
`ifdef PIXEL_SCALER_AVG_EN
        // Keep sampling the block until its bottom-right sample has arrived.
        if (mode_q && !(bi_q == fm1_q && bj_q == fm1_q)) begin
          sum_d = sum_next;
          if (bj_q == fm1_q) begin
            bj_d = '0;
            bi_d = bi_q + 2'd1;
          end else begin
            bj_d = bj_q + 2'd1;
          end
          state_d = S_FETCH;
        end else begin
          pix_d   = mode_q ? PIX_W'(sum_next >> {sh_q, 1'b0}) : src_data;
          sum_d   = '0;
          bi_d    = '0;
          bj_d    = '0;
          state_d = S_WRITE;
        end
`else
        pix_d   = src_data;
        state_d = S_WRITE;
`endif
      end
      S_WRITE: begin
        dst_addr_d = dst_calc;
        if (dst_ready) begin
          if (!mode_q && dj_q != fm1_q) begin
            dj_d = dj_q + 2'd1;
          end else if (!mode_q && di_q != fm1_q) begin
            dj_d = '0;
            di_d = di_q + 2'd1;
          end else begin
            dj_d = '0;
            di_d = '0;
            if (c_q != last_c) begin
              c_d     = c_q + CW'(1);
              state_d = S_FETCH;
            end else if (r_q != last_r) begin
              c_d     = '0;
              r_d     = r_q + RW'(1);
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      sh_q       <= '0;
      fm1_q      <= '0;
      r_q        <= '0;
      c_q        <= '0;
      di_q       <= '0;
      dj_q       <= '0;
      pix_q      <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
`ifdef PIXEL_SCALER_AVG_EN
      bi_q       <= '0;
      bj_q       <= '0;
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sh_q       <= sh_d;
      fm1_q      <= fm1_d;
      r_q        <= r_d;
      c_q        <= c_d;
      di_q       <= di_d;
      dj_q       <= dj_d;
      pix_q      <= pix_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
`ifdef PIXEL_SCALER_AVG_EN
      bi_q       <= bi_d;
      bj_q       <= bj_d;
      sum_q      <= sum_d;
`endif
    end
  end

endmodule
